// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the arbiter and the
// register file write port, plus the pending-write scoreboard mask.
interface regfile_wb_arbiter_if;
  logic        s0_valid;
  logic [4:0]  s0_addr;
  logic [31:0] s0_data;
  logic        s0_ready;

  logic        s1_valid;
  logic [4:0]  s1_addr;
  logic [31:0] s1_data;
  logic        s1_ready;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending_mask;

  // Pipeline side: drives requests, observes readiness and the write port.
  modport master (
    output s0_valid, s0_addr, s0_data,
    input  s0_ready,
    output s1_valid, s1_addr, s1_data,
    input  s1_ready,
    input  wr_en, wr_addr, wr_data, pending_mask
  );

  // Arbiter side.
  modport slave (
    input  s0_valid, s0_addr, s0_data,
    output s0_ready,
    input  s1_valid, s1_addr, s1_data,
    output s1_ready,
    output wr_en, wr_addr, wr_data, pending_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: two per-source FIFOs (ALU and load
// results) share the single write port round-robin, one write per clock.
// A pending-write mask covers everything queued or currently issuing so the
// issue stage can stall on RAW/WAW hazards.
module regfile_wb_arbiter #(
  parameter int DEPTH   = 2,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_t;

  wb_entry_t        mem [2][DEPTH];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [CNT_W-1:0] count [2];

  wb_entry_t        in_entry [2];
  wb_entry_t        head [2];
  wb_entry_t        pop_entry;
  logic [1:0]       in_valid;
  logic [1:0]       ready;
  logic [1:0]       nonempty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             issue;
  src_t             last_grant;
  src_t             grant_next;

  logic             wr_en_q;
  logic [4:0]       wr_addr_q;
  logic [31:0]      wr_data_q;
  logic [31:0]      mask;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Gather both sources into indexed form and derive FIFO status from the
  // registered counts only, so readiness never depends on this cycle's pop.
  // NOTE: every signal written here gets a default first; a path that leaves
  // a combinational output unassigned would infer a latch.
  always_comb begin
    in_valid    = {bus.s1_valid, bus.s0_valid};
    in_entry[0] = '{addr: bus.s0_addr, data: bus.s0_data};
    in_entry[1] = '{addr: bus.s1_addr, data: bus.s1_data};
    for (int s = 0; s < 2; s++) begin
      ready[s]    = (count[s] < CNT_W'(DEPTH));
      nonempty[s] = (count[s] != '0);
      head[s]     = mem[s][rd_ptr[s]];
      push[s]     = in_valid[s] && ready[s];
    end
  end

  // Round-robin pick among non-empty FIFOs; the pointer only moves on
  // contention, so a lone source never steals its rival's next turn.
  always_comb begin
    pop        = '0;
    grant_next = last_grant;
    if (nonempty[0] && nonempty[1]) begin
      if (last_grant == SRC1) begin
        pop[0]     = 1'b1;
        grant_next = SRC0;
      end else begin
        pop[1]     = 1'b1;
        grant_next = SRC1;
      end
    end else if (nonempty[0]) begin
      pop[0] = 1'b1;
    end else if (nonempty[1]) begin
      pop[1] = 1'b1;
    end
    pop_entry = pop[1] ? head[1] : head[0];
    issue     = (|pop) && !(DROP_R0 && (pop_entry.addr == 5'd0));
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the
  // count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= next_ptr(wr_ptr[s]);
        if (pop[s])  rd_ptr[s] <= next_ptr(rd_ptr[s]);
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + 1'b1;
          2'b01:   count[s] <= count[s] - 1'b1;
          default: count[s] <= count[s];
        endcase
      end
    end
  end

  // FIFO storage writes.
  // NOTE: the storage array is deliberately not reset; occupancy is tracked
  // by the reset counts, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= in_entry[s];
    end
  end

  // Write-port register and round-robin pointer; a dropped r0 write still
  // pops and moves the pointer but leaves the port idle and holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      last_grant <= SRC1;
    end else begin
      last_grant <= grant_next;
      wr_en_q    <= issue;
      if (issue) begin
        wr_addr_q <= pop_entry.addr;
        wr_data_q <= pop_entry.data;
      end
    end
  end

  // Scoreboard: decode every occupied FIFO slot plus the issuing write.
  always_comb begin
    logic [PTR_W-1:0] offset;
    mask = '0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < DEPTH; j++) begin
        offset = PTR_W'(j) - rd_ptr[s];
        if ((CNT_W'(offset) < count[s]) &&
            !(DROP_R0 && (mem[s][j].addr == 5'd0))) begin
          mask[mem[s][j].addr] = 1'b1;
        end
      end
    end
    if (wr_en_q) mask[wr_addr_q] = 1'b1;
  end

  assign bus.s0_ready     = ready[0];
  assign bus.s1_ready     = ready[1];
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.pending_mask = mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of directed vectors,
// hand-written multi-cycle sequences, and randomized traffic compared
// against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH   = 2;
  localparam bit DROP_R0 = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DROP_R0(DROP_R0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic        r0;
    logic        r1;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  vec_t vecs [15];

  // Reference model state.
  ent_t        q0 [$];
  ent_t        q1 [$];
  int          m_last;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  // Pending requests held by the stimulus until accepted.
  logic        p0_v, p1_v;
  logic [4:0]  p0_a, p1_a;
  logic [31:0] p0_d, p1_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.s0_valid = v0; bus.s0_addr = a0; bus.s0_data = d0;
    bus.s1_valid = v1; bus.s1_addr = a1; bus.s1_data = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_wr_addr", bus.wr_addr, 0);
    check("reset_wr_data", bus.wr_data, 0);
    check("reset_mask", bus.pending_mask, 0);
    check("reset_s0_ready", bus.s0_ready, 1);
    check("reset_s1_ready", bus.s1_ready, 1);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    m_last = 1;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
    p0_v   = 1'b0;
    p1_v   = 1'b0;
  endtask

  // One clock of the reference model: ready from queue depth, arbitration
  // from the queues as they stood before this edge, then enqueue.
  task automatic model_step();
    logic        r0, r1, popped;
    int          g;
    ent_t        e;
    logic [31:0] m_mask;
    r0 = (q0.size() < DEPTH);
    r1 = (q1.size() < DEPTH);
    check("s0_ready", bus.s0_ready, r0);
    check("s1_ready", bus.s1_ready, r1);
    drive(p0_v, p0_a, p0_d, p1_v, p1_a, p1_d);
    popped = 1'b0;
    g      = 0;
    e      = '0;
    if (q0.size() > 0 && q1.size() > 0) begin
      g = (m_last == 1) ? 0 : 1;
      m_last = g;
      popped = 1'b1;
    end else if (q0.size() > 0) begin
      g = 0;
      popped = 1'b1;
    end else if (q1.size() > 0) begin
      g = 1;
      popped = 1'b1;
    end
    if (popped) e = (g == 0) ? q0.pop_front() : q1.pop_front();
    m_en = 1'b0;
    if (popped && !(DROP_R0 && e.addr == 0)) begin
      m_en   = 1'b1;
      m_addr = e.addr;
      m_data = e.data;
    end
    if (p0_v && r0) begin q0.push_back('{addr: p0_a, data: p0_d}); p0_v = 1'b0; end
    if (p1_v && r1) begin q1.push_back('{addr: p1_a, data: p1_d}); p1_v = 1'b0; end
    m_mask = '0;
    foreach (q0[i]) if (!(DROP_R0 && q0[i].addr == 0)) m_mask[q0[i].addr] = 1'b1;
    foreach (q1[i]) if (!(DROP_R0 && q1[i].addr == 0)) m_mask[q1[i].addr] = 1'b1;
    if (m_en) m_mask[m_addr] = 1'b1;
    tick();
    check("model_wr_en", bus.wr_en, m_en);
    check("model_wr_addr", bus.wr_addr, m_addr);
    check("model_wr_data", bus.wr_data, m_data);
    check("model_mask", bus.pending_mask, m_mask);
  endtask

  initial begin
    // Single write, full round-robin burst with held s1 request, then r0 drop.
    vecs[0]  = '{1'b1, 5'd3, 32'hAA,  1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   32'h8,  1'b1, 1'b1};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b1, 5'd3, 32'hAA,  32'h8,  1'b1, 1'b1};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 5'd3, 32'hAA,  32'h0,  1'b1, 1'b1};
    vecs[3]  = '{1'b1, 5'd1, 32'h101, 1'b1, 5'd5, 32'h205, 1'b0, 5'd3, 32'hAA,  32'h22, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 5'd2, 32'h102, 1'b1, 5'd6, 32'h206, 1'b1, 5'd1, 32'h101, 32'h66, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd3, 32'h103, 1'b1, 5'd7, 32'h207, 1'b1, 5'd5, 32'h205, 32'h6C, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd7, 32'h207, 1'b1, 5'd2, 32'h102, 32'hCC, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b1, 5'd6, 32'h206, 32'hC8, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b1, 5'd3, 32'h103, 32'h88, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b1, 5'd7, 32'h207, 32'h80, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 5'd7, 32'h207, 32'h0,  1'b1, 1'b1};
    vecs[11] = '{1'b1, 5'd0, 32'hEE,  1'b0, 5'd0, 32'h0,   1'b0, 5'd7, 32'h207, 32'h0,  1'b1, 1'b1};
    vecs[12] = '{1'b1, 5'd4, 32'h44,  1'b0, 5'd0, 32'h0,   1'b0, 5'd7, 32'h207, 32'h10, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b1, 5'd4, 32'h44,  32'h10, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,   1'b0, 5'd4, 32'h44,  32'h0,  1'b1, 1'b1};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    apply_reset();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      tick();
      check($sformatf("vec%0d_wr_en", i), bus.wr_en, vecs[i].en);
      check($sformatf("vec%0d_wr_addr", i), bus.wr_addr, vecs[i].addr);
      check($sformatf("vec%0d_wr_data", i), bus.wr_data, vecs[i].data);
      check($sformatf("vec%0d_mask", i), bus.pending_mask, vecs[i].mask);
      check($sformatf("vec%0d_s0_ready", i), bus.s0_ready, vecs[i].r0);
      check($sformatf("vec%0d_s1_ready", i), bus.s1_ready, vecs[i].r1);
    end

    // Same register from both sources one cycle apart.
    apply_reset();
    drive(1, 5'd9, 32'h9A, 0, 0, 0);
    tick();
    check("waw_mask_q", bus.pending_mask, 32'h200);
    check("waw_en_q", bus.wr_en, 0);
    drive(0, 0, 0, 1, 5'd9, 32'h9B);
    tick();
    check("waw_first_en", bus.wr_en, 1);
    check("waw_first_data", bus.wr_data, 32'h9A);
    check("waw_first_mask", bus.pending_mask, 32'h200);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("waw_second_en", bus.wr_en, 1);
    check("waw_second_addr", bus.wr_addr, 9);
    check("waw_second_data", bus.wr_data, 32'h9B);
    check("waw_second_mask", bus.pending_mask, 32'h200);
    tick();
    check("waw_done_en", bus.wr_en, 0);
    check("waw_done_mask", bus.pending_mask, 0);

    // Asynchronous reset mid-burst, between clock edges.
    apply_reset();
    drive(1, 5'd1, 32'h11, 1, 5'd5, 32'h55);
    tick();
    drive(1, 5'd2, 32'h22, 1, 5'd6, 32'h66);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("arst_pre_en", bus.wr_en, 1);
    check("arst_pre_mask", bus.pending_mask, 32'h66);
    #3;
    reset = 1'b1;
    #1;
    check("arst_wr_en", bus.wr_en, 0);
    check("arst_mask", bus.pending_mask, 0);
    check("arst_wr_addr", bus.wr_addr, 0);
    check("arst_s0_ready", bus.s0_ready, 1);
    check("arst_s1_ready", bus.s1_ready, 1);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_after_en", bus.wr_en, 0);
      check("arst_after_mask", bus.pending_mask, 0);
    end

    // s1 alone for DEPTH+1 requests, with the write side free to drain.
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      p1_v = 1'b1; p1_a = 5'(10 + i); p1_d = 32'h1000 + 32'(i);
      model_step();
    end
    for (int i = 0; i < 3; i++) model_step();

    // Both sources streaming: FIFOs fill, s1 must hold until space appears.
    for (int i = 0; i < 12; i++) begin
      if (!p0_v) begin p0_v = 1'b1; p0_a = 5'(16 + (i % 8)); p0_d = 32'h2000 + 32'(i); end
      if (!p1_v) begin p1_v = 1'b1; p1_a = 5'(24 + (i % 8)); p1_d = 32'h3000 + 32'(i); end
      model_step();
    end
    for (int i = 0; i < 6; i++) model_step();

    // Randomized traffic with small address range to force hazards and r0.
    for (int i = 0; i < 2000; i++) begin
      if (!p0_v && $urandom_range(0, 9) < 6) begin
        p0_v = 1'b1; p0_a = 5'($urandom_range(0, 7)); p0_d = $urandom;
      end
      if (!p1_v && $urandom_range(0, 9) < 6) begin
        p1_v = 1'b1; p1_a = 5'($urandom_range(0, 7)); p1_d = $urandom;
      end
      model_step();
    end
    p0_v = 1'b0;
    p1_v = 1'b0;
    for (int i = 0; i < 6; i++) model_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
